// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - opcodes, state encoding and instruction field layout for prog_seq_core
package prog_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_JMP = 2'b01;
    localparam logic [1:0] OP_JNZ = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Stored word is {op, dest, src, value} with value in the LSBs.
    function automatic int src_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int dest_lsb(input int data_w, input int reg_w);
        return data_w + reg_w;
    endfunction

    function automatic int op_lsb(input int data_w, input int reg_w);
        return data_w + 2 * reg_w;
    endfunction

    function automatic int instr_width(input int data_w, input int reg_w);
        return 2 + 2 * reg_w + data_w;
    endfunction

endpackage

// File: rtl/prog_seq_regfile.sv
// rtl/prog_seq_regfile.sv - general register file, one write port, one async read port
module prog_seq_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    localparam int REG_W = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [REG_W-1:0]       waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [REG_W-1:0]       raddr,
    output logic [DATA_W-1:0]      rdata,
    output logic [NREG*DATA_W-1:0] regs_flat
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata = regs_q[raddr];

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

endmodule

// File: rtl/prog_seq_core.sv
// rtl/prog_seq_core.sv - programmable sequencer: front-panel program load, run/halt FSM, add/jump execution
module prog_seq_core
    import prog_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int PC_W   = 4,
    localparam int REG_W   = $clog2(NREG),
    localparam int INSTR_W = instr_width(DATA_W, REG_W)
) (
    input  logic                   advance,
    input  logic                   reset,
    input  logic                   prog,
    input  logic                   run,
    input  logic [1:0]             op,
    input  logic [REG_W-1:0]       dest,
    input  logic [REG_W-1:0]       src,
    input  logic [DATA_W-1:0]      value,
    output logic [PC_W-1:0]        pc,
    output logic [DATA_W-1:0]      o_b,
    output logic [NREG*DATA_W-1:0] o_regs,
    output logic                   carry,
    output logic                   halted,
    output logic [PC_W:0]          prog_len,
    output logic                   prog_full
);

    localparam int DEPTH    = 2 ** PC_W;
    localparam int SRC_LSB  = src_lsb(DATA_W);
    localparam int DEST_LSB = dest_lsb(DATA_W, REG_W);
    localparam int OP_LSB   = op_lsb(DATA_W, REG_W);
    localparam logic [PC_W:0] DEPTH_LEN = (PC_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   o_b_q, o_b_d;
    logic                carry_q, carry_d;
    logic [PC_W:0]       prog_len_q, prog_len_d;

    logic [INSTR_W-1:0]  mem [DEPTH];
    logic                mem_we;
    logic [PC_W-1:0]     mem_waddr;
    logic [INSTR_W-1:0]  mem_wdata;

    logic [INSTR_W-1:0]  cur_instr;
    logic [1:0]          ins_op;
    logic [REG_W-1:0]    ins_dest;
    logic [REG_W-1:0]    ins_src;
    logic [DATA_W-1:0]   ins_value;
    logic [PC_W-1:0]     jmp_tgt;
    logic [DATA_W-1:0]   jmp_tgt_ext;
    logic                in_range;
    logic                full_w;

    logic                rf_we;
    logic [DATA_W-1:0]   rf_rdata;
    logic [DATA_W:0]     sum;

    assign cur_instr   = mem[pc_q];
    assign ins_op      = cur_instr[OP_LSB +: 2];
    assign ins_dest    = cur_instr[DEST_LSB +: REG_W];
    assign ins_src     = cur_instr[SRC_LSB +: REG_W];
    assign ins_value   = cur_instr[DATA_W-1:0];
    assign jmp_tgt     = ins_value[PC_W-1:0];
    assign jmp_tgt_ext = DATA_W'(jmp_tgt);
    // Entries at or beyond prog_len are stale or unwritten; fetching them halts.
    assign in_range    = {1'b0, pc_q} < prog_len_q;
    assign full_w      = prog_len_q == DEPTH_LEN;
    assign sum         = {1'b0, rf_rdata} + {1'b0, ins_value};
    assign mem_wdata   = {op, dest, src, value};

    prog_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk       (advance),
        .rst       (reset),
        .we        (rf_we),
        .waddr     (ins_dest),
        .wdata     (sum[DATA_W-1:0]),
        .raddr     (ins_src),
        .rdata     (rf_rdata),
        .regs_flat (o_regs)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        o_b_d      = o_b_q;
        carry_d    = carry_q;
        prog_len_d = prog_len_q;
        mem_we     = 1'b0;
        mem_waddr  = prog_len_q[PC_W-1:0];
        rf_we      = 1'b0;
        if (prog) begin
            state_d = ST_LOAD;
            if (state_q != ST_LOAD) begin
                mem_we     = 1'b1;
                mem_waddr  = '0;
                prog_len_d = (PC_W+1)'(1);
            end else if (!full_w) begin
                mem_we     = 1'b1;
                prog_len_d = prog_len_q + (PC_W+1)'(1);
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    pc_d    = '0;
                    state_d = run ? ST_RUN : ST_IDLE;
                end
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_RUN;
                        pc_d    = '0;
                    end
                end
                ST_HALT: begin
                    // pc still points at the halting instruction; resume past it.
                    if (run) begin
                        state_d = ST_RUN;
                        pc_d    = pc_q + PC_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!in_range) begin
                        state_d = ST_HALT;
                    end else begin
                        case (ins_op)
                            OP_ADD: begin
                                rf_we   = 1'b1;
                                carry_d = sum[DATA_W];
                                o_b_d   = sum[DATA_W-1:0];
                                pc_d    = pc_q + PC_W'(1);
                            end
                            OP_JMP: begin
                                pc_d  = jmp_tgt;
                                o_b_d = jmp_tgt_ext;
                            end
                            OP_JNZ: begin
                                if (rf_rdata != '0) begin
                                    pc_d  = jmp_tgt;
                                    o_b_d = jmp_tgt_ext;
                                end else begin
                                    pc_d = pc_q + PC_W'(1);
                                end
                            end
                            default: begin
                                state_d = ST_HALT;
                            end
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge advance or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            o_b_q      <= '0;
            carry_q    <= 1'b0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            o_b_q      <= o_b_d;
            carry_q    <= carry_d;
            prog_len_q <= prog_len_d;
        end
    end

    always_ff @(posedge advance) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign pc        = pc_q;
    assign o_b       = o_b_q;
    assign carry     = carry_q;
    assign prog_len  = prog_len_q;
    assign halted    = state_q == ST_HALT;
    assign prog_full = full_w;

endmodule
